// File: rtl/minterm_sweep_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | minterm_sweep_pkg : shared FSM encoding and limits for the minterm sweeper |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package minterm_sweep_pkg;
  localparam int SETTLE_MIN = 1;
  localparam int N_IN_MAX   = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    EMIT = 2'd2,
    FIN  = 2'd3
  } sweep_state_t;
endpackage
`default_nettype wire

// File: rtl/minterm_sweep_settle_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | minterm_sweep_settle_timer : counts SETTLE cycles per vector, flags the    |
// | sample cycle on last_o.                                                    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module minterm_sweep_settle_timer
  import minterm_sweep_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic last_o
);
  localparam int c_settle = (SETTLE < SETTLE_MIN) ? SETTLE_MIN : SETTLE;
  localparam int c_cw     = (c_settle > 1) ? $clog2(c_settle) : 1;

  logic [c_cw-1:0] r_cnt;
  logic            r_run;

  // load restarts the window even if the previous one is ending this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (load_i) begin
      r_cnt <= c_cw'(c_settle - 1);
      r_run <= 1'b1;
    end else if (r_run) begin
      if (r_cnt == '0) r_run <= 1'b0;
      else             r_cnt <= r_cnt - c_cw'(1);
    end
  end

  assign last_o = r_run && (r_cnt == '0);
endmodule
`default_nettype wire

// File: rtl/minterm_sweep_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | minterm_sweep_reader : sweeps all 2^N_IN vectors into a netlist and streams|
// | ON-set minterm indices. MINTERM_SWEEP_DC_EN adds dc_i / m_dc.              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module minterm_sweep_reader
  import minterm_sweep_pkg::*;
#(
  parameter int N_IN   = 14,
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] vec_o,
  input  logic            f_i,
`ifdef MINTERM_SWEEP_DC_EN
  input  logic            dc_i,
  output logic            m_dc,
`endif
  output logic            m_valid,
  input  logic            m_ready,
  output logic [N_IN-1:0] m_index,
  output logic            busy,
  output logic            done,
  output logic [N_IN:0]   ones_cnt
);
  localparam logic [N_IN-1:0] c_vec_max = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] c_vec_one = N_IN'(1);
  localparam logic [N_IN:0]   c_cnt_one = (N_IN + 1)'(1);

  sweep_state_t    r_state;
  logic [N_IN-1:0] r_vec;
  logic [N_IN-1:0] r_index;
  logic [N_IN:0]   r_ones;
  logic            r_valid;
  logic            r_busy;
  logic            r_done;
  logic            r_m_dc;

  logic w_last;
  logic w_dc_smp;
  logic w_emit;
  logic w_at_max;
  logic w_xfer;
  logic w_exit;
  logic w_load;

`ifdef MINTERM_SWEEP_DC_EN
  assign w_dc_smp = dc_i;
  assign m_dc     = r_m_dc;
`else
  assign w_dc_smp = 1'b0;
`endif

  assign w_emit   = f_i | w_dc_smp;
  assign w_at_max = (r_vec == c_vec_max);
  assign w_xfer   = (r_state == EMIT) && r_valid && m_ready;
  // leaving the current vector: sampled OFF, or its index was just accepted
  assign w_exit   = ((r_state == HOLD) && w_last && !w_emit) || w_xfer;
  assign w_load   = ((r_state == IDLE) && start) || (w_exit && !w_at_max);

  minterm_sweep_settle_timer #(
    .SETTLE(SETTLE)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load_i(w_load),
    .last_o(w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_vec   <= '0;
      r_index <= '0;
      r_ones  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_m_dc  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_vec   <= '0;
            r_ones  <= '0;
            r_busy  <= 1'b1;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (w_last && w_emit) begin
            r_valid <= 1'b1;
            r_index <= r_vec;
            r_m_dc  <= w_dc_smp;
            r_state <= EMIT;
          end
        end
        EMIT: begin
          if (w_xfer) begin
            r_valid <= 1'b0;
            if (!r_m_dc) r_ones <= r_ones + c_cnt_one;
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      // advance shares the HOLD/EMIT exit cycle, so no extra state is spent
      if (w_exit) begin
        if (w_at_max) begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= FIN;
        end else begin
          r_vec   <= r_vec + c_vec_one;
          r_state <= HOLD;
        end
      end
    end
  end

  assign vec_o    = r_vec;
  assign m_valid  = r_valid;
  assign m_index  = r_index;
  assign busy     = r_busy;
  assign done     = r_done;
  assign ones_cnt = r_ones;
endmodule
`default_nettype wire

// File: tb/tb_minterm_sweep_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_minterm_sweep_reader : directed table-driven bench, N_IN=3, SETTLE=2    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_minterm_sweep_reader;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] vec_o;
  logic       f_i;
  logic       dc_i;
  logic       m_dc;
  logic       m_valid;
  logic       m_ready;
  logic [2:0] m_index;
  logic       busy;
  logic       done;
  logic [3:0] ones_cnt;
  int         mode;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  minterm_sweep_reader #(.N_IN(3), .SETTLE(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .vec_o   (vec_o),
    .f_i     (f_i),
`ifdef MINTERM_SWEEP_DC_EN
    .dc_i    (dc_i),
    .m_dc    (m_dc),
`endif
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_index (m_index),
    .busy    (busy),
    .done    (done),
    .ones_cnt(ones_cnt)
  );

  // netlist under test models
  always_comb begin
    f_i = 1'b0;
    case (mode)
      0: f_i = vec_o[0] & vec_o[1];
      1: f_i = 1'b0;
      2: f_i = 1'b1;
      3: f_i = vec_o[2];
      4: f_i = (vec_o == 3'd5);
      5: f_i = (vec_o == 3'd6);
      6: f_i = (vec_o == 3'd0) || (vec_o == 3'd7);
      default: f_i = 1'b0;
    endcase
  end
  assign dc_i = (mode == 5) && (vec_o == 3'd1);
`ifndef MINTERM_SWEEP_DC_EN
  assign m_dc = 1'b0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // one sweep from IDLE; returns after the IDLE cycle that follows FIN
  task automatic run_sweep(input int stall, input int poke_vec, input bit poke_fin,
                           output int cyc, output int mask, output int ones,
                           output int errs, output int ndone);
    int  wait_cnt;
    int  last_idx;
    bit  pv;
    bit  poked;
    logic [2:0] pidx, pvec;
    cyc = -1; mask = 0; ones = -1; errs = 0; ndone = 0;
    wait_cnt = 0; last_idx = -1; pv = 0; poked = 0; pidx = '0; pvec = '0;
    start   = 1'b1;
    m_ready = (stall == 0);
    @(posedge clk); #1;
    for (int c = 1; c <= 300; c++) begin
      start = 1'b0;
      if (c == 1 && !busy) errs++;
      if (pv && (m_index !== pidx || vec_o !== pvec || !m_valid)) errs++;
      if (done) begin
        ndone++;
        if (cyc < 0) begin
          cyc  = c;
          ones = int'(ones_cnt);
          if (busy) errs++;
          if (poke_fin) start = 1'b1;
        end
      end
      if (cyc >= 0 && c == cyc + 1) begin
        if (busy) errs++;
        break;
      end
      if (busy && poke_vec >= 0 && !poked && int'(vec_o) == poke_vec) begin
        start = 1'b1;
        poked = 1;
      end
      if (m_valid) begin
        m_ready = (wait_cnt >= stall);
        if (m_ready) begin
          if (int'(m_index) <= last_idx) errs++;
          last_idx = int'(m_index);
          mask     = mask | (1 << m_index);
          wait_cnt = 0;
          pv       = 0;
        end else begin
          wait_cnt++;
          pv   = 1;
          pidx = m_index;
          pvec = vec_o;
        end
      end else begin
        m_ready = 1'b1;
        pv      = 0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  typedef struct {
    int mode;
    int stall;
    int poke_vec;
    bit poke_fin;
    int exp_mask;
    int exp_ones;
    int exp_cyc;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int cyc, mask, ones, errs, ndone;
    bit ok;
    tbl[0] = '{0, 0, -1, 1'b0, 'h88, 2, 19};
    tbl[1] = '{1, 0, -1, 1'b0, 'h00, 0, 17};
    tbl[2] = '{2, 3, -1, 1'b0, 'hFF, 8, 49};
    tbl[3] = '{3, 1, -1, 1'b1, 'hF0, 4, 25};
    tbl[4] = '{0, 0,  4, 1'b0, 'h88, 2, 19};
    tbl[5] = '{6, 2, -1, 1'b0, 'h81, 2, 23};

    rst_n = 1'b0; start = 1'b0; m_ready = 1'b0; mode = 1;
    #3;
    chk("reset_vec",     int'(vec_o), 0);
    chk("reset_valid",   int'(m_valid), 0);
    chk("reset_index",   int'(m_index), 0);
    chk("reset_busy",    int'(busy), 0);
    chk("reset_done",    int'(done), 0);
    chk("reset_ones",    int'(ones_cnt), 0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      mode = tbl[i].mode;
      run_sweep(tbl[i].stall, tbl[i].poke_vec, tbl[i].poke_fin, cyc, mask, ones, errs, ndone);
      chk($sformatf("t%0d_cycles", i), cyc, tbl[i].exp_cyc);
      chk($sformatf("t%0d_mask", i), mask, tbl[i].exp_mask);
      chk($sformatf("t%0d_ones", i), ones, tbl[i].exp_ones);
      chk($sformatf("t%0d_seq_errs", i), errs, 0);
      chk($sformatf("t%0d_done_pulses", i), ndone, 1);
    end

    // reset while EMIT holds index 5 under backpressure
    mode = 4; m_ready = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    ok = 0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(posedge clk); #1;
      if (m_valid) ok = 1;
    end
    chk("emit_reached", int'(ok), 1);
    chk("emit_index", int'(m_index), 5);
    repeat (3) @(posedge clk);
    #1;
    chk("emit_hold_index", int'(m_index), 5);
    chk("emit_hold_vec", int'(vec_o), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outputs", int'({vec_o, m_valid, m_index, busy, done, ones_cnt}), 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    mode = 0;
    run_sweep(0, -1, 1'b0, cyc, mask, ones, errs, ndone);
    chk("post_rst_cycles", cyc, 19);
    chk("post_rst_mask", mask, 'h88);
    chk("post_rst_seq_errs", errs, 0);

`ifdef MINTERM_SWEEP_DC_EN
    begin
      int idx[2];
      int dcs[2];
      int n;
      mode = 5; m_ready = 1'b1; start = 1'b1; n = 0; cyc = -1;
      @(posedge clk); #1 start = 1'b0;
      for (int c = 1; c <= 100 && cyc < 0; c++) begin
        if (m_valid) begin
          if (n < 2) begin
            idx[n] = int'(m_index);
            dcs[n] = int'(m_dc);
          end
          n++;
        end
        if (done) cyc = c;
        if (cyc < 0) begin
          @(posedge clk); #1;
        end
      end
      chk("dc_items", n, 2);
      chk("dc_idx0", idx[0], 1);
      chk("dc_flag0", dcs[0], 1);
      chk("dc_idx1", idx[1], 6);
      chk("dc_flag1", dcs[1], 0);
      chk("dc_ones", int'(ones_cnt), 1);
      chk("dc_cycles", cyc, 19);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
